dp_sram_bytewise: RTL

//   Parametrised true dual-port SRAM with per-port byte-enable writes and configurable read latency.

---
 rtl/dp_sram_pkg.sv | 21 ++
 rtl/dp_sram_rdpipe.sv | 45 ++++
 rtl/dp_sram_bytewise.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dp_sram_pkg.sv
// Shared types and helpers for the byte-wise dual-port scratch RAM.
// Holds the sweep-clear states, collision priorities and byte merge.
package dp_sram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam int PRI_A = 0;
  localparam int PRI_B = 1;

  function automatic logic [7:0] be_merge(
    input logic [7:0] old,
    input logic [7:0] wdata,
    input logic       be
  );
    return be ? wdata : old;
  endfunction

endpackage

// File: rtl/dp_sram_rdpipe.sv
// Read-data pipeline for one port: RD_LAT stages of data plus valid.
// Data stages load only behind a valid, so the output holds between reads.
module dp_sram_rdpipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  logic [DATA_W-1:0] d [RD_LAT];
  logic [RD_LAT-1:0] v;

  for (genvar i = 0; i < RD_LAT; i++) begin : g_stage
    if (i == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (flush) begin
          v[0] <= 1'b0;
          d[0] <= '0;
        end else begin
          v[0] <= in_valid;
          if (in_valid) d[0] <= in_data;
        end
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (flush) begin
          v[i] <= 1'b0;
          d[i] <= '0;
        end else begin
          v[i] <= v[i-1];
          if (v[i-1]) d[i] <= d[i-1];
        end
      end
    end
  end

  assign rdata  = d[RD_LAT-1];
  assign rvalid = v[RD_LAT-1];

endmodule

// File: rtl/dp_sram_bytewise.sv
// True dual-port byte-enable SRAM with read-valid strobes,
// write/write collision arbitration and a post-reset sweep clear.
module dp_sram_bytewise
  import dp_sram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int BE_W         = DATA_W / 8,
  parameter int RD_LAT       = 1,
  parameter int COLLIDE_PRI  = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chip_sel,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [BE_W-1:0]   a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  output logic              a_collide,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [BE_W-1:0]   b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              b_collide,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;

  logic a_acc, b_acc;
  logic a_wr, b_wr, both_wr;
  logic a_wr_en, b_wr_en;
  logic [DATA_W-1:0] a_merged, b_merged;

  assign a_acc   = chip_sel & a_req & init_done;
  assign b_acc   = chip_sel & b_req & init_done;
  assign a_wr    = a_acc & a_we;
  assign b_wr    = b_acc & b_we;
  assign both_wr = a_wr & b_wr & (a_addr == b_addr);

  // The loser is dropped whole, even with disjoint byte enables.
  assign a_wr_en = a_wr & ~(both_wr & (COLLIDE_PRI == PRI_B));
  assign b_wr_en = b_wr & ~(both_wr & (COLLIDE_PRI == PRI_A));

  always_comb begin
    a_merged = mem[a_addr];
    b_merged = mem[b_addr];
    for (int i = 0; i < BE_W; i++) begin
      a_merged[8*i +: 8] = be_merge(mem[a_addr][8*i +: 8],
                                    a_wdata[8*i +: 8], a_be[i]);
      b_merged[8*i +: 8] = be_merge(mem[b_addr][8*i +: 8],
                                    b_wdata[8*i +: 8], b_be[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
      clr_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST) begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        READY: init_done <= 1'b1;
      endcase
    end
  end

  // Single write process; reads sample mem before these updates land.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= '0;
      end else begin
        if (a_wr_en) mem[a_addr] <= a_merged;
        if (b_wr_en) mem[b_addr] <= b_merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_collide <= 1'b0;
      b_collide <= 1'b0;
    end else begin
      a_collide <= both_wr & (COLLIDE_PRI == PRI_B);
      b_collide <= both_wr & (COLLIDE_PRI == PRI_A);
    end
  end

  dp_sram_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe_a (
    .clk      (clk),
    .flush    (reset),
    .in_valid (a_acc & ~a_we),
    .in_data  (mem[a_addr]),
    .rdata    (a_rdata),
    .rvalid   (a_rvalid)
  );

  dp_sram_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe_b (
    .clk      (clk),
    .flush    (reset),
    .in_valid (b_acc & ~b_we),
    .in_data  (mem[b_addr]),
    .rdata    (b_rdata),
    .rvalid   (b_rvalid)
  );

endmodule
